entropy_collector: RTL and testbench

Consumer end of the entropy source interface used in the TRNG. Drains 32-bit words from an avalanche-style entropy provider over its enabled/data/valid/ack handshake, packs NUM_WORDS words into one block for the downstream mixer, and runs a repetition-count health test that flags stuck sources, such as a simulation source that returns a constant word.

---
 rtl/entropy_collector.sv | 201 ++++++++++++++++++++
 tb/tb_entropy_collector.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/entropy_collector.sv
// -----------------------------------------------------------------------------
// entropy_collector
//
// Consumer side of the TRNG entropy source handshake. Words are drained from
// the provider one at a time, packed NUM_WORDS per block for the downstream
// mixer (first word ends up in the MSBs), and screened by a repetition-count
// health test that latches health_error when the source repeats one word
// REP_LIMIT times in a row.
//
// Parameters:
//   NUM_WORDS       words per output block (2..255)
//   REP_LIMIT       consecutive identical words that trip the health test
//
// Ports:
//   clk             system clock, rising edge
//   reset_n         asynchronous active-low reset
//   enable          collector enable; low aborts and discards the block
//   entropy_enabled source is running; low stalls capture
//   entropy_data    source word
//   entropy_valid   source word valid, held until acked
//   entropy_ack     one-cycle pulse consuming the captured word
//   block_data      collected block, word 0 in the MSBs
//   block_syn       block available, held until block_ack
//   block_ack       downstream accepts the block
//   health_error    sticky repetition-test failure
//   health_clear    clears health_error and leaves the error state
//   word_count      words captured into the current block
// -----------------------------------------------------------------------------
module entropy_collector #(
  parameter int NUM_WORDS = 16,
  parameter int REP_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   entropy_enabled,
  input  logic [31:0]            entropy_data,
  input  logic                   entropy_valid,
  output logic                   entropy_ack,
  output logic [NUM_WORDS*32-1:0] block_data,
  output logic                   block_syn,
  input  logic                   block_ack,
  output logic                   health_error,
  input  logic                   health_clear,
  output logic [7:0]             word_count
);

  localparam int BW = NUM_WORDS * 32;
  localparam logic [7:0] NUM_WORDS_L = 8'(NUM_WORDS);
  localparam logic [7:0] REP_LIMIT_L = 8'(REP_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    ACK,
    FULL,
    ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   block_q, block_d;
  logic [7:0]      word_count_q, word_count_d;
  logic [7:0]      rep_count_q, rep_count_d;
  logic [31:0]     prev_word_q, prev_word_d;
  logic            ack_q, ack_d;
  logic            syn_q, syn_d;
  logic            err_q, err_d;

  // Per-capture intermediates
  logic [7:0]      rep_next;
  logic [7:0]      count_next;

  // Next-state and output logic. The ack pulse defaults low so it can only
  // ever last the single cycle following a capture.
  always_comb begin
    state_d      = state_q;
    block_d      = block_q;
    word_count_d = word_count_q;
    rep_count_d  = rep_count_q;
    prev_word_d  = prev_word_q;
    ack_d        = 1'b0;
    syn_d        = syn_q;
    err_d        = err_q;
    rep_next     = rep_count_q;
    count_next   = word_count_q + 8'd1;

    case (state_q)
      IDLE: begin
        word_count_d = 8'd0;
        rep_count_d  = 8'd0;
        prev_word_d  = 32'd0;
        block_d      = '0;
        syn_d        = 1'b0;
        if (enable) begin
          state_d = COLLECT;
        end
      end

      COLLECT: begin
        if (!enable) begin
          state_d      = IDLE;
          word_count_d = 8'd0;
          syn_d        = 1'b0;
        end else if (entropy_enabled && entropy_valid) begin
          block_d     = {block_q[BW-33:0], entropy_data};
          prev_word_d = entropy_data;
          // rep_count of 0 means no word seen yet, so even a zero word
          // coming out of IDLE starts a fresh run.
          if ((entropy_data == prev_word_q) && (rep_count_q != 8'd0)) begin
            rep_next = rep_count_q + 8'd1;
          end else begin
            rep_next = 8'd1;
          end
          rep_count_d = rep_next;
          // A tripped health test wins over everything: the offending word
          // is never acked and the partial block is abandoned.
          if (rep_next == REP_LIMIT_L) begin
            state_d      = ERROR;
            err_d        = 1'b1;
            word_count_d = 8'd0;
          end else begin
            word_count_d = count_next;
            ack_d        = 1'b1;
            if (count_next == NUM_WORDS_L) begin
              state_d = FULL;
              syn_d   = 1'b1;
            end else begin
              state_d = ACK;
            end
          end
        end
      end

      ACK: begin
        if (!enable) begin
          state_d      = IDLE;
          word_count_d = 8'd0;
          syn_d        = 1'b0;
        end else begin
          state_d = COLLECT;
        end
      end

      FULL: begin
        if (!enable) begin
          state_d      = IDLE;
          word_count_d = 8'd0;
          syn_d        = 1'b0;
        end else if (block_ack) begin
          state_d      = COLLECT;
          word_count_d = 8'd0;
          syn_d        = 1'b0;
        end
      end

      ERROR: begin
        word_count_d = 8'd0;
        syn_d        = 1'b0;
        if (health_clear) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything at once,
  // including an ack that is mid-pulse and a pending block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      block_q      <= '0;
      word_count_q <= 8'd0;
      rep_count_q  <= 8'd0;
      prev_word_q  <= 32'd0;
      ack_q        <= 1'b0;
      syn_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      block_q      <= block_d;
      word_count_q <= word_count_d;
      rep_count_q  <= rep_count_d;
      prev_word_q  <= prev_word_d;
      ack_q        <= ack_d;
      syn_q        <= syn_d;
      err_q        <= err_d;
    end
  end

  assign entropy_ack  = ack_q;
  assign block_data   = block_q;
  assign block_syn    = syn_q;
  assign health_error = err_q;
  assign word_count   = word_count_q;

endmodule

// File: tb/tb_entropy_collector.sv
// -----------------------------------------------------------------------------
// tb_entropy_collector
//
// Self-checking bench for entropy_collector. A software source feeds words
// from a queue and retires the head word whenever an ack is seen. Directed
// scenarios come from a table of records with their expected outcomes;
// randomized streams are predicted by a word-list model (run lengths and
// block slicing) independent of the design's state machine.
// -----------------------------------------------------------------------------
module tb_entropy_collector;

  localparam int NUM_WORDS = 16;
  localparam int REP_LIMIT = 4;
  localparam int BW = NUM_WORDS * 32;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic          entropy_enabled;
  logic [31:0]   entropy_data;
  logic          entropy_valid;
  logic          entropy_ack;
  logic [BW-1:0] block_data;
  logic          block_syn;
  logic          block_ack;
  logic          health_error;
  logic          health_clear;
  logic [7:0]    word_count;

  int checks_total;
  int checks_passed;

  logic [31:0]   src_q[$];
  logic [31:0]   sent[$];
  logic [BW-1:0] obs_blocks[$];
  int            ack_count;
  int            ack_wide;
  bit            ack_prev;
  bit            auto_ack;
  bit            rnd_stall;
  int            wait_target;

  typedef struct {
    string       name;
    int          mode;
    logic [31:0] base;
    int          n;
    int          exp_acks;
    bit          exp_syn;
    bit          exp_err;
    int          exp_wc;
  } vec_t;

  vec_t vecs[6];

  entropy_collector #(
    .NUM_WORDS(NUM_WORDS),
    .REP_LIMIT(REP_LIMIT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .entropy_enabled (entropy_enabled),
    .entropy_data    (entropy_data),
    .entropy_valid   (entropy_valid),
    .entropy_ack     (entropy_ack),
    .block_data      (block_data),
    .block_syn       (block_syn),
    .block_ack       (block_ack),
    .health_error    (health_error),
    .health_clear    (health_clear),
    .word_count      (word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic check_block(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // One clock of the software source and block consumer, evaluated on the
  // falling edge so every DUT output is stable when sampled.
  task automatic tick();
    @(negedge clk);
    if (entropy_ack === 1'b1) begin
      ack_count++;
      if (ack_prev) ack_wide++;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    ack_prev = (entropy_ack === 1'b1);
    if (auto_ack) begin
      if (block_syn && !block_ack) begin
        obs_blocks.push_back(block_data);
        block_ack = 1'b1;
      end else begin
        block_ack = 1'b0;
      end
    end
    if (rnd_stall) entropy_enabled = ($urandom_range(0, 3) != 0);
    entropy_valid = (src_q.size() > 0);
    entropy_data  = entropy_valid ? src_q[0] : $urandom();
  endtask

  function automatic bit cond(input int kind);
    case (kind)
      0: return block_syn;
      1: return health_error;
      2: return (src_q.size() == 0) && !entropy_ack;
      3: return block_syn || health_error || ((src_q.size() == 0) && !entropy_ack);
      4: return entropy_ack;
      5: return ack_count >= wait_target;
      default: return health_error ||
                 ((src_q.size() == 0) && !entropy_ack && !block_syn && !block_ack);
    endcase
  endfunction

  task automatic wait_cond(input int kind, input int budget, input string name);
    int n = 0;
    while (!cond(kind)) begin
      if (n >= budget) begin
        checks_total++;
        $display("[TB] FAIL %s: timed out after %0d cycles, expected condition %0d", name, n, kind);
        break;
      end
      tick();
      n++;
    end
  endtask

  function automatic logic [31:0] gen_word(input int mode, input logic [31:0] base, input int i);
    case (mode)
      0: return base + 32'(i);
      1: return base;
      2: return (i < 3) ? base : base + 32'd1;
      3: return base + 32'(i / 2);
      default: return base + 32'(i / 3);
    endcase
  endfunction

  // Reference: index of the capture whose run of identical words reaches
  // REP_LIMIT, or -1 if the stream stays healthy.
  function automatic int model_trip(input logic [31:0] w[$]);
    int run = 0;
    for (int i = 0; i < w.size(); i++) begin
      if (i > 0 && w[i] == w[i-1]) run++;
      else run = 1;
      if (run == REP_LIMIT) return i;
    end
    return -1;
  endfunction

  function automatic logic [BW-1:0] model_block(input logic [31:0] w[$], input int first);
    logic [BW-1:0] blk = '0;
    for (int j = 0; j < NUM_WORDS; j++) blk[(NUM_WORDS-1-j)*32 +: 32] = w[first+j];
    return blk;
  endfunction

  // Drop enable long enough to land in IDLE, which resets the run tracking.
  task automatic restart();
    auto_ack  = 1'b0;
    block_ack = 1'b0;
    enable    = 1'b0;
    src_q.delete();
    tick();
    tick();
    sent.delete();
    obs_blocks.delete();
    ack_count = 0;
    enable    = 1'b1;
    tick();
  endtask

  task automatic push_words(input int mode, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      src_q.push_back(gen_word(mode, base, i));
      sent.push_back(gen_word(mode, base, i));
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    restart();
    push_words(v.mode, v.base, v.n);
    wait_cond(3, 300, {v.name, "_done"});
    tick();
    tick();
    checkOutput({v.name, "_acks"}, 64'(ack_count), 64'(v.exp_acks));
    checkOutput({v.name, "_syn"}, 64'(block_syn), 64'(v.exp_syn));
    checkOutput({v.name, "_err"}, 64'(health_error), 64'(v.exp_err));
    checkOutput({v.name, "_wc"}, 64'(word_count), 64'(v.exp_wc));
    if (v.exp_syn) begin
      check_block({v.name, "_block"}, block_data, model_block(sent, 0));
      block_ack = 1'b1;
      tick();
      block_ack = 1'b0;
      checkOutput({v.name, "_syn_after_ack"}, 64'(block_syn), 64'd0);
      checkOutput({v.name, "_wc_after_ack"}, 64'(word_count), 64'd0);
    end
    if (v.exp_err) begin
      src_q.delete();
      health_clear = 1'b1;
      tick();
      health_clear = 1'b0;
      checkOutput({v.name, "_err_cleared"}, 64'(health_error), 64'd0);
    end
  endtask

  initial begin
    int n, trip, exp_acks, exp_blocks, nb;
    logic [31:0] base, last, w;

    checks_total = 0;
    checks_passed = 0;
    ack_count = 0;
    ack_wide = 0;
    ack_prev = 1'b0;
    auto_ack = 1'b0;
    rnd_stall = 1'b0;
    wait_target = 0;
    reset_n = 1'b0;
    enable = 1'b0;
    entropy_enabled = 1'b1;
    entropy_valid = 1'b0;
    entropy_data = 32'd0;
    block_ack = 1'b0;
    health_clear = 1'b0;

    vecs[0] = '{"inc16",    0, 32'h1,        16, 16, 1'b1, 1'b0, 16};
    vecs[1] = '{"const4",   1, 32'h11223344, 4,  3,  1'b0, 1'b1, 0};
    vecs[2] = '{"aaabbbb",  2, 32'hA0,       7,  6,  1'b0, 1'b1, 0};
    vecs[3] = '{"pairs16",  3, 32'h500,      16, 16, 1'b1, 1'b0, 16};
    vecs[4] = '{"inc5",     0, 32'h77,       5,  5,  1'b0, 1'b0, 5};
    vecs[5] = '{"triple16", 4, 32'h900,      16, 16, 1'b1, 1'b0, 16};

    tick();
    tick();
    checkOutput("reset_ack", 64'(entropy_ack), 64'd0);
    checkOutput("reset_syn", 64'(block_syn), 64'd0);
    checkOutput("reset_err", 64'(health_error), 64'd0);
    checkOutput("reset_wc", 64'(word_count), 64'd0);
    check_block("reset_block", block_data, '0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // After clearing a health error the run count starts over: three more
    // copies of the stuck word are acked, the fourth trips again.
    restart();
    push_words(1, 32'h11223344, 4);
    wait_cond(1, 100, "stuck_trip");
    src_q.delete();
    health_clear = 1'b1;
    tick();
    health_clear = 1'b0;
    ack_count = 0;
    push_words(1, 32'h11223344, 3);
    wait_cond(2, 100, "restart_three");
    tick();
    checkOutput("restart_err_low", 64'(health_error), 64'd0);
    checkOutput("restart_acks", 64'(ack_count), 64'd3);
    push_words(1, 32'h11223344, 1);
    wait_cond(1, 20, "restart_fourth_trip");
    checkOutput("restart_err_high", 64'(health_error), 64'd1);
    checkOutput("restart_no_fourth_ack", 64'(ack_count), 64'd3);
    src_q.delete();
    health_clear = 1'b1;
    tick();
    health_clear = 1'b0;

    // Source stall mid-block: nothing captured, then the block completes.
    restart();
    push_words(0, 32'h100, 16);
    wait_target = 8;
    wait_cond(5, 100, "stall_first8");
    entropy_enabled = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("stall_wc_held", 64'(word_count), 64'd8);
    checkOutput("stall_no_acks", 64'(ack_count), 64'd8);
    entropy_enabled = 1'b1;
    wait_cond(0, 100, "stall_resume");
    check_block("stall_block", block_data, model_block(sent, 0));
    checkOutput("stall_acks", 64'(ack_count), 64'd16);

    // enable dropped while the block is waiting for the consumer.
    enable = 1'b0;
    tick();
    checkOutput("full_abort_syn", 64'(block_syn), 64'd0);
    checkOutput("full_abort_wc", 64'(word_count), 64'd0);

    // enable dropped after seven words: partial block discarded.
    restart();
    push_words(0, 32'h200, 16);
    wait_target = 7;
    wait_cond(5, 100, "abort_first7");
    enable = 1'b0;
    tick();
    checkOutput("abort_wc", 64'(word_count), 64'd0);
    checkOutput("abort_syn", 64'(block_syn), 64'd0);
    restart();
    push_words(0, 32'h300, 16);
    wait_cond(0, 100, "abort_next_block");
    check_block("abort_fresh_block", block_data, model_block(sent, 0));
    checkOutput("abort_fresh_wc", 64'(word_count), 64'd16);

    // Asynchronous reset while an ack is on the wire.
    restart();
    push_words(0, 32'h400, 6);
    wait_cond(4, 50, "reset_wait_ack");
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_ack", 64'(entropy_ack), 64'd0);
    checkOutput("async_rst_syn", 64'(block_syn), 64'd0);
    checkOutput("async_rst_err", 64'(health_error), 64'd0);
    checkOutput("async_rst_wc", 64'(word_count), 64'd0);
    check_block("async_rst_block", block_data, '0);
    src_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    ack_count = 0;
    push_words(0, 32'h500, 2);
    wait_cond(2, 50, "stray_ack_words");
    tick();
    checkOutput("stray_ack_wc_before", 64'(word_count), 64'd2);
    block_ack = 1'b1;
    tick();
    block_ack = 1'b0;
    tick();
    checkOutput("stray_ack_wc_after", 64'(word_count), 64'd2);
    checkOutput("stray_ack_syn", 64'(block_syn), 64'd0);

    // Randomized streams from a small alphabet so runs are common.
    for (int t = 0; t < 16; t++) begin
      restart();
      auto_ack = 1'b1;
      rnd_stall = 1'b1;
      n = $urandom_range(18, 40);
      base = $urandom();
      last = base;
      for (int i = 0; i < n; i++) begin
        if (i > 0 && $urandom_range(0, 1) == 1) w = last;
        else w = base + 32'($urandom_range(0, 2));
        src_q.push_back(w);
        sent.push_back(w);
        last = w;
      end
      trip = model_trip(sent);
      exp_acks = (trip >= 0) ? trip : n;
      exp_blocks = exp_acks / NUM_WORDS;
      wait_cond(6, 2000, "rand_done");
      rnd_stall = 1'b0;
      entropy_enabled = 1'b1;
      tick();
      tick();
      tick();
      checkOutput("rand_acks", 64'(ack_count), 64'(exp_acks));
      checkOutput("rand_err", 64'(health_error), 64'(trip >= 0));
      checkOutput("rand_blocks", 64'(obs_blocks.size()), 64'(exp_blocks));
      nb = (obs_blocks.size() < exp_blocks) ? obs_blocks.size() : exp_blocks;
      for (int b = 0; b < nb; b++)
        check_block("rand_block", obs_blocks[b], model_block(sent, b * NUM_WORDS));
      auto_ack = 1'b0;
      block_ack = 1'b0;
      src_q.delete();
      health_clear = 1'b1;
      tick();
      health_clear = 1'b0;
    end

    checkOutput("ack_single_cycle", 64'(ack_wide), 64'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
